bcd_countdown_timer: RTL

//  Loadable BCD down-counter: the counting-down counterpart of the BCD seconds counter.

---
 rtl/bcd_countdown_timer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - loadable BCD countdown timer (ts:ss.ds, 00.0..59.9 s)
//
// Counts a loaded preset down to 00.0 in tenth-of-second steps and pulses
// `expired` for one cycle when zero is reached. Sits beside the BCD seconds
// up-counter, sharing its tick enable and display path.
//
// Optional build macro: AUTO_RELOAD_EN
//   defined   - on reaching zero the count reloads from the stored preset in
//               the same edge, the timer keeps running and `expired` still
//               pulses once per period (a zero preset falls back to stopping).
//   undefined - the timer stops at 00.0 in EXPIRED; preset is only stored.
//
// Parameters
//   TS_MAX    highest legal tens-of-seconds digit (load clamps to it)
//   PRESCALE  enable pulses per ds decrement (>=1)
//
// Ports
//   clk      in   clock, all state changes on its rising edge
//   reset    in   synchronous active-high reset
//   enable   in   time tick
//   load     in   load ld_ts/ld_ss/ld_ds into count and preset
//   ld_ts    in   [2:0] preset tens-of-seconds digit
//   ld_ss    in   [3:0] preset single-seconds digit
//   ld_ds    in   [3:0] preset tenths-of-seconds digit
//   start    in   begin or resume counting
//   stop     in   pause counting
//   ts       out  [2:0] current tens-of-seconds digit
//   ss       out  [3:0] current single-seconds digit
//   ds       out  [3:0] current tenths-of-seconds digit
//   running  out  high while counting
//   expired  out  one-cycle pulse after the step that reaches zero

module bcd_countdown_timer #(
    parameter int TS_MAX   = 5,
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [2:0] ld_ts,
    input  logic [3:0] ld_ss,
    input  logic [3:0] ld_ds,
    input  logic       start,
    input  logic       stop,
    output logic [2:0] ts,
    output logic [3:0] ss,
    output logic [3:0] ds,
    output logic       running,
    output logic       expired
);

    // A PRESCALE of 1 still gets a 1-bit counter that simply stays at zero,
    // so every enable in RUN is a step.
    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [2:0]    TS_LIM     = 3'(TS_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    ts_q, ts_d;
    logic [3:0]    ss_q, ss_d;
    logic [3:0]    ds_q, ds_d;
    logic [2:0]    pts_q, pts_d;
    logic [3:0]    pss_q, pss_d;
    logic [3:0]    pds_q, pds_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          expired_q, expired_d;

    // Clamped load digits
    logic [2:0] cl_ts;
    logic [3:0] cl_ss;
    logic [3:0] cl_ds;

    // Count after one decrement step
    logic [2:0] st_ts;
    logic [3:0] st_ss;
    logic [3:0] st_ds;
    logic       step_zero;

    logic load_ok;
    logic start_ok;
    logic go_nz;

    always_comb begin
        cl_ts = (ld_ts > TS_LIM) ? TS_LIM : ld_ts;
        cl_ss = (ld_ss > 4'd9)   ? 4'd9   : ld_ss;
        cl_ds = (ld_ds > 4'd9)   ? 4'd9   : ld_ds;
    end

    // BCD decrement with borrow chain ds -> ss -> ts. ts saturates at zero,
    // which is unreachable in practice since RUN never holds a zero count.
    always_comb begin
        st_ts = ts_q;
        st_ss = ss_q;
        st_ds = ds_q;
        if (ds_q != 4'd0) begin
            st_ds = ds_q - 4'd1;
        end else begin
            st_ds = 4'd9;
            if (ss_q != 4'd0) begin
                st_ss = ss_q - 4'd1;
            end else begin
                st_ss = 4'd9;
                if (ts_q != 3'd0) begin
                    st_ts = ts_q - 3'd1;
                end
            end
        end
        step_zero = (st_ts == 3'd0) && (st_ss == 4'd0) && (st_ds == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ts_q      <= 3'd0;
            ss_q      <= 4'd0;
            ds_q      <= 4'd0;
            pts_q     <= 3'd0;
            pss_q     <= 4'd0;
            pds_q     <= 4'd0;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            ss_q      <= ss_d;
            ds_q      <= ds_d;
            pts_q     <= pts_d;
            pss_q     <= pss_d;
            pds_q     <= pds_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q;
        ss_d      = ss_q;
        ds_d      = ds_q;
        pts_d     = pts_q;
        pss_d     = pss_q;
        pds_d     = pds_q;
        presc_d   = presc_q;
        expired_d = 1'b0;

        load_ok = load && (state_q != RUN);

        // A load in the same cycle puts the timer in IDLE first, so start is
        // judged on the freshly loaded digits; stop always beats start.
        start_ok = start && !stop &&
                   (load_ok || (state_q == IDLE) || (state_q == HOLD));
        go_nz    = load_ok ? ((cl_ts != 3'd0) || (cl_ss != 4'd0) || (cl_ds != 4'd0))
                           : ((ts_q  != 3'd0) || (ss_q  != 4'd0) || (ds_q  != 4'd0));

        if (load_ok) begin
            ts_d    = cl_ts;
            ss_d    = cl_ss;
            ds_d    = cl_ds;
            pts_d   = cl_ts;
            pss_d   = cl_ss;
            pds_d   = cl_ds;
            presc_d = '0;
            state_d = IDLE;
        end

        if (start_ok && go_nz) begin
            presc_d = '0;
            state_d = RUN;
        end

        if (state_q == RUN) begin
            if (stop) begin
                // Pausing discards any partial prescale so a resume starts a
                // full tick period.
                presc_d = '0;
                state_d = HOLD;
            end else if (enable) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    ts_d    = st_ts;
                    ss_d    = st_ss;
                    ds_d    = st_ds;
                    if (step_zero) begin
                        expired_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                        if ((pts_q != 3'd0) || (pss_q != 4'd0) || (pds_q != 4'd0)) begin
                            ts_d = pts_q;
                            ss_d = pss_q;
                            ds_d = pds_q;
                        end else begin
                            state_d = EXPIRED;
                        end
`else
                        state_d = EXPIRED;
`endif
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        end
    end

    assign ts      = ts_q;
    assign ss      = ss_q;
    assign ds      = ds_q;
    assign running = (state_q == RUN);
    assign expired = expired_q;

endmodule
